// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N-channel button conditioner: synchroniser, hysteresis integrator, rise/fall/hold pulses
module debounce_bank #(
    parameter int N_CH        = 5,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 22,
    parameter int TH_HI       = 2**21,
    parameter int TH_LO       = 2**20,
    parameter int HOLD_CYCLES = 50000000,
    parameter int REPEAT_CYC  = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    localparam int HMAX      = (HOLD_CYCLES > REPEAT_CYC) ? HOLD_CYCLES : REPEAT_CYC;
    localparam int HW        = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
    localparam int HOLD_LD_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int REP_LD_I  = (REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TH_HI_C   = CNT_W'(TH_HI);
    localparam logic [CNT_W-1:0] TH_LO_C   = CNT_W'(TH_LO);
    localparam logic [HW-1:0]    HOLD_LD   = HW'(HOLD_LD_I);
    localparam logic [HW-1:0]    REP_LD    = HW'(REP_LD_I);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic [HW-1:0]          hcnt_q, hcnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   hold_q, hold_d;
        logic                   hdone_q, hdone_d;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in[i]};
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            hold_d  = 1'b0;
            hcnt_d  = hcnt_q;
            hdone_d = hdone_q;

            if (s && cnt_q != CNT_MAX_C) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!s && cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end

            // hcnt counts down to the next hold pulse; hdone parks it once no more pulses are due
            if (!level_q) begin
                hcnt_d  = '0;
                hdone_d = 1'b0;
                if (cnt_q >= TH_HI_C) begin
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    hcnt_d  = HOLD_LD;
                    hdone_d = (HOLD_CYCLES == 0);
                end
            end else if (cnt_q <= TH_LO_C) begin
                level_d = 1'b0;
                fall_d  = 1'b1;
                hcnt_d  = '0;
                hdone_d = 1'b0;
            end else if (!hdone_q) begin
                if (hcnt_q == '0) begin
                    hold_d = 1'b1;
                    if (REPEAT_CYC != 0) begin
                        hcnt_d = REP_LD;
                    end else begin
                        hdone_d = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q - HW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q  <= '0;
                cnt_q   <= '0;
                hcnt_q  <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                hold_q  <= 1'b0;
                hdone_q <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                cnt_q   <= cnt_d;
                hcnt_q  <= hcnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                hold_q  <= hold_d;
                hdone_q <= hdone_d;
            end
        end

        assign level_out[i] = level_q;
        assign rise[i]      = rise_q;
        assign fall[i]      = fall_q;
        assign hold[i]      = hold_q;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank with a cycle-level behavioural model
module tb_debounce_bank;

    localparam int N_CH  = 2;
    localparam int SYNC  = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
    localparam int TH_HI = 12;
    localparam int TH_LO = 3;
    localparam int HOLDC = 20;
    localparam int REPC  = 8;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] level_out, rise, fall, hold;

    int vectors;
    int miscompares;

    debounce_bank #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .TH_HI(TH_HI),
        .TH_LO(TH_LO), .HOLD_CYCLES(HOLDC), .REPEAT_CYC(REPC)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level_out(level_out), .rise(rise), .fall(fall), .hold(hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N_CH-1:0] got, input logic [N_CH-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Model: input seen SYNC edges ago drives a saturating count; hold timing derived from distance to rise
    int              m_cnt  [N_CH];
    bit [SYNC-1:0]   m_hist [N_CH];
    longint          m_k    [N_CH];
    longint          cyc;
    logic [N_CH-1:0] m_lvl, m_rise, m_fall, m_hold;
    bit              m_valid;

    always @(posedge clk) begin
        cyc++;
        for (int ch = 0; ch < N_CH; ch++) begin
            bit     s;
            int     old;
            longint d;
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            m_hold[ch] = 1'b0;
            if (rst) begin
                m_cnt[ch]  = 0;
                m_hist[ch] = '0;
                m_lvl[ch]  = 1'b0;
            end else begin
                s   = m_hist[ch][SYNC-1];
                old = m_cnt[ch];
                m_hist[ch] = {m_hist[ch][SYNC-2:0], btn_in[ch]};
                m_cnt[ch]  = s ? ((old < CMAX) ? old + 1 : old) : ((old > 0) ? old - 1 : 0);
                if (!m_lvl[ch] && old >= TH_HI) begin
                    m_lvl[ch]  = 1'b1;
                    m_rise[ch] = 1'b1;
                    m_k[ch]    = cyc;
                end else if (m_lvl[ch] && old <= TH_LO) begin
                    m_lvl[ch]  = 1'b0;
                    m_fall[ch] = 1'b1;
                end else if (m_lvl[ch]) begin
                    d = cyc - m_k[ch];
                    m_hold[ch] = (d == HOLDC) || (REPC != 0 && d > HOLDC && (d - HOLDC) % REPC == 0);
                end
            end
        end
        if (rst) m_valid = 1'b1;
        #1;
        if (m_valid) begin
            chk("model_level", level_out, m_lvl);
            chk("model_rise",  rise,      m_rise);
            chk("model_fall",  fall,      m_fall);
            chk("model_hold",  hold,      m_hold);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit bad;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        m_valid     = 1'b0;
        m_lvl       = '0;
        rst         = 1'b1;
        btn_in      = 2'b11;

        // 1: reset held 3 edges with buttons pressed, and one cycle after
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk("reset_outputs", level_out | rise | fall | hold, 2'b00);
        end
        rst = 1'b0;
        tick();
        chk("post_reset_outputs", level_out | rise | fall | hold, 2'b00);
        btn_in = 2'b00;
        repeat (10) tick();

        // 3: bounce from cnt=0
        bad = 1'b0;
        for (int e = 0; e < 40; e++) begin
            btn_in[0] = e[0];
            tick();
            if ((level_out | rise | fall) !== 2'b00) bad = 1'b1;
        end
        chk("bounce_no_change", {1'b0, bad}, 2'b00);
        btn_in = 2'b00;
        repeat (10) tick();

        // 2: clean press on ch0
        btn_in = 2'b01;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (e == 14) chk("press_level_e14", level_out, 2'b00);
        end
        chk("press_rise_e15",  rise,      2'b01);
        chk("press_level_e15", level_out, 2'b01);

        // 5: long press, rise was d=0
        for (int d = 1; d <= 62; d++) begin
            tick();
            if (d == 1)  chk("rise_one_cycle", rise, 2'b00);
            if (d == 19) chk("hold_d19", hold, 2'b00);
            if (d == 20) chk("hold_d20", hold, 2'b01);
            if (d == 21) chk("hold_d21", hold, 2'b00);
            if (d == 28) chk("hold_d28", hold, 2'b01);
            if (d == 36) chk("hold_d36", hold, 2'b01);
            if (d == 44) chk("hold_d44", hold, 2'b01);
            if (d == 1 || d == 30) chk("ch1_idle", level_out[1] | rise[1] | hold[1], 1'b0);
        end

        // 4: release from saturated count
        btn_in = 2'b00;
        for (int r = 1; r <= 15; r++) begin
            tick();
            if (r == 14) chk("release_level_e14", level_out, 2'b01);
        end
        chk("release_fall_e15",  fall,      2'b01);
        chk("release_level_e15", level_out, 2'b00);
        bad = 1'b0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if ((hold | fall | rise) !== 2'b00) bad = 1'b1;
        end
        chk("no_hold_after_release", {1'b0, bad}, 2'b00);

        // 6: reset mid-press, ch1 pressed 5 cycles later than ch0
        btn_in = 2'b01;
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e == 5)  btn_in = 2'b11;
            if (e == 15) chk("ch0_rise_independent", rise, 2'b01);
        end
        chk("pre_reset_level", level_out, 2'b01);
        rst = 1'b1;
        tick();
        chk("midpress_reset_level", level_out, 2'b00);
        chk("midpress_reset_fall",  fall,      2'b00);
        rst    = 1'b0;
        btn_in = 2'b10;
        bad    = 1'b0;
        for (int r = 1; r <= 15; r++) begin
            tick();
            if (fall !== 2'b00) bad = 1'b1;
            if (r == 14) chk("ch1_level_e14", level_out, 2'b00);
        end
        chk("ch1_rise_e15",  rise,      2'b10);
        chk("ch1_level_e15", level_out, 2'b10);
        chk("no_fall_after_reset", {1'b0, bad}, 2'b00);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
